// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Holds the receiver state encoding and the baud divisor calculation.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    int unsigned os_rate;
    os_rate = baud * OVERSAMPLE;
    return (clk_freq + os_rate / 2) / os_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO with occupancy count and overrun pulse.
// A read frees a slot in the same cycle, so write+read at full succeeds.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_C);
  assign count   = cnt;
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= wr_en & ~do_wr;
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver (8N1) with majority-vote bit decisions
// feeding a show-ahead receive FIFO.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = 1;

  logic          rx_s1, rx_s2, rx_q;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          restart;

  rx_state_t     state, state_n;
  logic [3:0]    s_cnt, s_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [1:0]    samp, samp_n;
  logic          vote;
  logic          wr_en;
  logic          ferr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  // Divider realigns to the start edge so ticks land on bit centres.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  div_cnt <= '0;
    else if (restart || tick) div_cnt <= '0;
    else                      div_cnt <= div_cnt + DIV_ONE;
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s_cnt     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      samp      <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      s_cnt     <= s_cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      samp      <= samp_n;
      frame_err <= ferr_n;
    end
  end

  // Majority of the samples from ticks 7 and 8 plus the live tick-9 sample.
  assign vote = (samp[0] & samp[1]) | (samp[0] & rx_s2) | (samp[1] & rx_s2);

  always_comb begin
    state_n   = state;
    s_cnt_n   = s_cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    samp_n    = samp;
    wr_en     = 1'b0;
    ferr_n    = 1'b0;
    restart   = 1'b0;

    if (state != IDLE && tick) begin
      s_cnt_n = s_cnt + 4'd1;
      if (s_cnt == 4'd7) samp_n[0] = rx_s2;
      if (s_cnt == 4'd8) samp_n[1] = rx_s2;
    end

    case (state)
      IDLE: begin
        if (rx_q && !rx_s2) begin
          state_n   = START;
          s_cnt_n   = '0;
          bit_idx_n = '0;
          restart   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt == 4'd9 && vote) begin
            state_n = IDLE;
            s_cnt_n = '0;
          end else if (s_cnt == 4'd15) begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt == 4'd9) shreg_n = {vote, shreg[7:1]};
          if (s_cnt == 4'd15) begin
            if (bit_idx == 3'd7) state_n = STOP;
            else                 bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick && s_cnt == 4'd9) begin
          state_n = IDLE;
          s_cnt_n = '0;
          if (vote) wr_en  = 1'b1;
          else      ferr_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (shreg),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: serial frames are driven bit by bit, a
// queue model of the FIFO predicts every byte popped and every error pulse.
module tb_uart_rx_os;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned BAUD     = 390_625;   // 16x rate = CLK_FREQ / 8
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned DIV      = 8;
  localparam int unsigned OS       = 16;
  localparam int unsigned BIT      = OS * DIV;
  // Edges from driving the start bit to the stop-bit write: 3 clocks of
  // synchroniser/edge detect, then 9 full bits plus 10 ticks into the stop bit.
  localparam int unsigned DECIDE   = 3 + (9 * OS + 10) * DIV;
  localparam int unsigned GLITCH   = 200 * BIT / 432;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       frame_err;
  logic       overrun;

  uart_rx_os #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [7:0]  exp_q[$];
  int unsigned ferr_seen = 0, ovr_seen = 0;
  int unsigned exp_ferr  = 0, exp_ovr  = 0;
  logic [7:0]  mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  // Monitor: every accepted pop is compared with the model queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_seen++;
      if (overrun)   ovr_seen++;
      if (rd_en && !empty) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rd_data: got %02h, want no byte", rd_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (rd_data !== mon_exp) begin
            miscompares++;
            $display("FAIL rd_data: got %02h, want %02h", rd_data, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit rd_sync);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rx = bits[i];
          repeat (BIT) @(posedge clk);
          #1;
        end
      end
      begin
        if (rd_sync) begin
          repeat (DECIDE - 1) @(posedge clk);
          #1 rd_en = 1'b1;
          @(posedge clk);
          #1 rd_en = 1'b0;
        end
      end
    join
    rx = 1'b1;
  endtask

  // Model of what a finished frame does to the FIFO and error pulses.
  task automatic account(input logic [7:0] b, input logic stop_bit);
    if (!stop_bit)                exp_ferr++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                          exp_ovr++;
  endtask

  task automatic read_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1 rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " count"}, 32'(count), 32'(exp_q.size()));
    check({tag, " empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, " full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    check({tag, " frame_err pulses"}, ferr_seen, exp_ferr);
    check({tag, " overrun pulses"}, ovr_seen, exp_ovr);
  endtask

  task automatic drain(input string tag);
    read_n(exp_q.size());
    idle(2);
    check_state(tag);
  endtask

  initial begin
    logic [7:0]  b;
    logic        sb;
    int unsigned lat;

    rst = 1'b1; rx = 1'b1; rd_en = 1'b0;
    idle(5);
    check("reset count", 32'(count), 0);
    check("reset empty", 32'(empty), 1);
    check("reset full", 32'(full), 0);
    check("reset rd_data", 32'(rd_data), 0);
    check("reset frame_err", 32'(frame_err), 0);
    check("reset overrun", 32'(overrun), 0);
    rst = 1'b0;
    idle(3);

    // 0xA5, with empty-fall latency measured from the start-bit drive
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        @(posedge clk);
        #1;
        while (empty && lat < DECIDE + BIT) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    account(8'hA5, 1'b1);
    vectors++;
    if (lat + 1 < DECIDE || lat > DECIDE + 1) begin
      miscompares++;
      $display("FAIL empty latency: got %0d clocks, want %0d +/-1", lat, DECIDE);
    end
    idle(4);
    check_state("a5");
    check("a5 head", 32'(rd_data), 32'h A5);
    drain("a5 drained");

    // reads while empty are ignored
    read_n(3);
    check_state("empty read");

    // short low glitch is a false start
    @(posedge clk);
    #1 rx = 1'b0;
    idle(GLITCH);
    rx = 1'b1;
    idle(2 * BIT);
    check_state("glitch");
    send_frame(8'h5A, 1'b1, 1'b0);
    account(8'h5A, 1'b1);
    idle(4);
    check_state("after glitch");
    drain("after glitch drained");

    // bad stop bit, then a good frame
    send_frame(8'h3C, 1'b0, 1'b0);
    account(8'h3C, 1'b0);
    idle(BIT);
    check_state("frame error");
    send_frame(8'h55, 1'b1, 1'b0);
    account(8'h55, 1'b1);
    idle(4);
    check_state("after frame error");
    drain("0x55 drained");

    // nine bytes, no reads
    for (int unsigned i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      account(8'(i), 1'b1);
      idle(4 * DIV);
      if (i == 8) check_state("eight bytes");
    end
    check_state("ninth byte");
    drain("nine drained");

    // full FIFO with a read in the write cycle
    for (int unsigned i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0);
      account(b, 1'b1);
    end
    idle(4);
    check_state("refill");
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b1);
    account(b, 1'b1);
    idle(4);
    check_state("write with read at full");
    drain("simultaneous drained");

    // reset during bit 4 of 0xF0; line stays high after release
    @(posedge clk);
    #1;
    rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      idle(BIT);
    end
    rx = 1'b1;
    idle(BIT / 4);
    rst = 1'b1;
    idle(5);
    rst = 1'b0;
    exp_q.delete();
    idle(6 * BIT);
    check_state("reset mid-frame");
    send_frame(8'hC3, 1'b1, 1'b0);
    account(8'hC3, 1'b1);
    idle(4);
    check_state("after reset");
    drain("0xC3 drained");

    // randomized frames, stop errors and interleaved reads
    for (int unsigned i = 0; i < 12; i++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      idle($urandom_range(0, BIT));
      send_frame(b, sb, 1'b0);
      account(b, sb);
      idle(4);
      read_n($urandom_range(0, 1));
    end
    idle(4);
    check_state("random");
    drain("random drained");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, at least 2).
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port rd_en, input, 1, pop head of FIFO.
REQ-008 SHALL have port rd_data, output, 8, FIFO head, show-ahead, valid while empty=0.
REQ-009 SHALL have port empty, output, 1, FIFO holds no bytes.
REQ-010 SHALL have port full, output, 1, FIFO holds FIFO_DEPTH bytes.
REQ-011 SHALL have port count, output, $clog2(FIFO_DEPTH)+1, bytes held.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1.
REQ-015 SHALL generate a tick every DIV = round(CLK_FREQ/(BAUD*16)) clocks (27 at defaults); the divider restarts when a start edge is detected.
REQ-016 SHALL implement states IDLE, START, DATA, STOP, with a 4-bit tick counter (0-15) per bit and a 3-bit bit index.
REQ-017 In IDLE, SHALL move to START on a synchronized 1->0 transition only; a line held low never retriggers.
REQ-018 In START, SHALL take the majority of samples at ticks 7, 8, 9; a result of 1 is a false start and returns to IDLE with no output; a result of 0 continues to DATA at tick 15.
REQ-019 In DATA, SHALL decide each bit by majority of ticks 7, 8, 9, shift it in LSB first, and go to STOP after bit index 7 completes tick 15.
REQ-020 In STOP, SHALL decide at tick 9 and return to IDLE in the same cycle, leaving half a bit for resynchronisation.
REQ-021 Stop=1 SHALL write the byte to the FIFO; stop=0 SHALL discard the byte and pulse frame_err for one cycle.
REQ-022 After a write, empty SHALL fall and rd_data SHALL be valid on the next clock edge.
REQ-023 rd_en with empty=1 SHALL be ignored, with no pointer or count change.
REQ-024 A write with full=1 and no rd_en SHALL drop the byte and pulse overrun; FIFO contents are unchanged.
REQ-025 A write and a read in the same cycle SHALL succeed, including at full, with count unchanged.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH.

Reset
REQ-027 On rst: state=IDLE, counters=0, shift register=0, FIFO pointers=0, count=0, empty=1, full=0, frame_err=0, overrun=0, rd_data=0.
REQ-028 Reset mid-frame SHALL abandon the frame; after release, reception SHALL restart only on a new falling edge.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum, the OVERSAMPLE=16 constant, and the divisor function.
REQ-030 The FIFO SHALL be a sub-module uart_rx_fifo with ports wr_en, wr_data, rd_en, rd_data, empty, full, count, overrun.

Verification
REQ-031 Serial 0xA5 at 432 clocks per bit -> rd_data=0xA5, empty falls within 1 clock of the mid-stop decision, count=1, no error pulses.
REQ-032 A 200-clock low glitch on idle line -> no write, state back in IDLE, count=0.
REQ-033 Byte 0x3C with stop bit driven 0 -> frame_err pulses once, count=0; a following 0x55 frame is received correctly.
REQ-034 Nine bytes 0x01..0x09 with no reads -> full=1 after 8, overrun pulses on the ninth, reads return 0x01..0x08 in order.
REQ-035 FIFO full with rd_en asserted in the write cycle -> count stays 8, no overrun, last byte read out in order.
REQ-036 rst asserted at bit 4 of a frame, released mid-frame -> no write; next full frame 0xC3 is received correctly.
